// File: rtl/data_deinterleaver.sv
// Purpose : receive-side OFDM de-interleaver. It buffers one symbol of N bits in a ping-pong
//           single-bit RAM, undoes the pair swap on write and the block permutation on read.
// Latency : the first output bit comes 3 cycles after the last input bit (read engine idle).
//           Output is then N back-to-back bits.
// Backpressure: none. The input is never stalled. A symbol that finds its target bank still
//           full is counted, dropped and flagged in the sticky deintv_ovf.
// Ports   : cb_clk/rst_n clock and async active-low reset.
//           deintv_din/_en: one input bit per enabled cycle.
//           deintv_con/signal_flag_in: symbol size and SIGNAL flag, taken with the first bit.
//           deintv_dout/_vld/_last/_type: de-interleaved output stream.
//           deintv_ovf: sticky drop indication.
module data_deinterleaver #(
  parameter int BANK_DEPTH = 288
) (
  input  logic       cb_clk,
  input  logic       rst_n,
  input  logic       deintv_din,
  input  logic       deintv_en,
  input  logic [1:0] deintv_con,
  input  logic       signal_flag_in,
  output logic       deintv_dout,
  output logic       deintv_vld,
  output logic       deintv_last,
  output logic [1:0] deintv_type,
  output logic       deintv_ovf
);
  localparam int AW = $clog2(2 * BANK_DEPTH);
  localparam int JW = $clog2(BANK_DEPTH);
  localparam logic [AW-1:0] BANK_OFS = AW'(BANK_DEPTH);

  function automatic logic [JW-1:0] last_idx(input logic [1:0] c);
    case (c)
      2'b00:   last_idx = JW'(47);
      2'b01:   last_idx = JW'(95);
      2'b10:   last_idx = JW'(191);
      default: last_idx = JW'(287);
    endcase
  endfunction

  // Block permutation (N/16)*(k mod 16) + k/16 built from shifts: 3=2+1, 6=4+2, 12=8+4, 18=16+2.
  function automatic logic [JW-1:0] blk_perm(input logic [JW-1:0] k, input logic [1:0] c);
    logic [JW-1:0] r;
    logic [JW-1:0] row;
    r   = JW'(k[3:0]);
    row = k >> 4;
    case (c)
      2'b00:   blk_perm = (r << 1) + r + row;
      2'b01:   blk_perm = (r << 2) + (r << 1) + row;
      2'b10:   blk_perm = (r << 3) + (r << 2) + row;
      default: blk_perm = (r << 4) + (r << 1) + row;
    endcase
  endfunction

  function automatic logic [AW-1:0] bank_ofs(input logic b);
    bank_ofs = b ? BANK_OFS : '0;
  endfunction

  // write side state
  logic [JW-1:0]   j_q;
  logic [4:0]      grp_q;          // j mod 24, restarted with every symbol
  logic [1:0]      con_q;
  logic            sig_q, drop_q, wr_bank_q, ovf_q;
  logic            wr_en_q, wr_dat_q;
  logic [AW-1:0]   wr_addr_q;
  // bank bookkeeping
  logic [1:0]      full_q;
  logic [1:0][1:0] bank_con_q;
  // read engine and output pipeline
  logic            rd_act_q, rd_bank_q;
  logic [JW-1:0]   k_q;
  logic            a_vld_q, a_last_q, b_vld_q, b_last_q, ram_q;
  logic [1:0]      a_type_q, b_type_q;
  logic [AW-1:0]   rd_addr_q;
  logic            dout_q, vld_q, last_q;
  logic [1:0]      type_q;
  logic            mem [2*BANK_DEPTH];

  // combinational next-state
  logic            sym_start, cur_sig, cur_drop, at_last, commit;
  logic [1:0]      cur_con, rd_con, full_d;
  logic [JW-1:0]   wr_a, rd_k;
  logic [AW-1:0]   wr_addr_d, rd_addr_d;
  logic            rd_start, rd_issue, rd_done;

  always_comb begin
    sym_start = (j_q == '0);
    // Symbol parameters come straight from the ports on the first bit, then from the latches.
    cur_con   = sym_start ? deintv_con : con_q;
    cur_sig   = sym_start ? signal_flag_in : sig_q;
    cur_drop  = sym_start ? full_q[wr_bank_q] : drop_q;
    at_last   = (j_q == last_idx(cur_con));
    wr_a      = j_q;
    // Undo the second-level pair swap in the upper half of every 24-bit group.
    if (!cur_sig && grp_q >= 5'd12) wr_a = {j_q[JW-1:2], ~j_q[1], j_q[0]};
    wr_addr_d = AW'(wr_a) + bank_ofs(wr_bank_q);
    commit    = deintv_en && at_last && !cur_drop;

    // Banks always complete alternately, so serving them alternately keeps completion order.
    rd_start  = !rd_act_q && full_q[rd_bank_q];
    rd_issue  = rd_act_q || rd_start;
    rd_k      = rd_act_q ? k_q : '0;
    rd_con    = bank_con_q[rd_bank_q];
    rd_done   = rd_issue && (rd_k == last_idx(rd_con));
    rd_addr_d = AW'(blk_perm(rd_k, rd_con)) + bank_ofs(rd_bank_q);

    // The release is applied before the completion. Both never hit the same bank.
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (commit)  full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge cb_clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q        <= '0;
      grp_q      <= '0;
      con_q      <= '0;
      sig_q      <= 1'b0;
      drop_q     <= 1'b0;
      wr_bank_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_dat_q   <= 1'b0;
      wr_addr_q  <= '0;
      full_q     <= '0;
      bank_con_q <= '0;
      rd_act_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      k_q        <= '0;
      a_vld_q    <= 1'b0;
      a_last_q   <= 1'b0;
      a_type_q   <= '0;
      rd_addr_q  <= '0;
      b_vld_q    <= 1'b0;
      b_last_q   <= 1'b0;
      b_type_q   <= '0;
      dout_q     <= 1'b0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      type_q     <= '0;
    end else begin
      if (deintv_en) begin
        if (sym_start) begin
          con_q  <= deintv_con;
          sig_q  <= signal_flag_in;
          drop_q <= full_q[wr_bank_q];
          if (full_q[wr_bank_q]) ovf_q <= 1'b1;
        end
        if (at_last) begin
          j_q   <= '0;
          grp_q <= '0;
          if (!cur_drop) begin
            wr_bank_q             <= ~wr_bank_q;
            bank_con_q[wr_bank_q] <= cur_con;
          end
        end else begin
          j_q   <= j_q + JW'(1);
          grp_q <= (grp_q == 5'd23) ? '0 : grp_q + 5'd1;
        end
      end
      // The RAM write lands one cycle after the bit is sampled.
      wr_en_q   <= deintv_en && !cur_drop;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= deintv_din;
      full_q    <= full_d;

      if (rd_issue) begin
        k_q      <= rd_k + JW'(1);
        rd_act_q <= !rd_done;
        if (rd_done) rd_bank_q <= ~rd_bank_q;
      end
      a_vld_q   <= rd_issue;
      a_last_q  <= rd_done;
      a_type_q  <= rd_con;
      rd_addr_q <= rd_addr_d;

      b_vld_q   <= a_vld_q;
      b_last_q  <= a_last_q;
      b_type_q  <= a_type_q;

      vld_q  <= b_vld_q;
      last_q <= b_last_q;
      dout_q <= b_vld_q & ram_q;
      if (b_vld_q) type_q <= b_type_q;
    end
  end

  always_ff @(posedge cb_clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_dat_q;
    ram_q <= mem[rd_addr_q];
  end

  assign deintv_dout = dout_q;
  assign deintv_vld  = vld_q;
  assign deintv_last = last_q;
  assign deintv_type = type_q;
  assign deintv_ovf  = ovf_q;
endmodule

// File: tb/tb_data_deinterleaver.sv
module tb_data_deinterleaver;
  logic       cb_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       deintv_din = 1'b0;
  logic       deintv_en = 1'b0;
  logic [1:0] deintv_con = 2'b00;
  logic       signal_flag_in = 1'b0;
  logic       deintv_dout, deintv_vld, deintv_last, deintv_ovf;
  logic [1:0] deintv_type;

  data_deinterleaver #(.BANK_DEPTH(288)) dut (
    .cb_clk(cb_clk), .rst_n(rst_n), .deintv_din(deintv_din), .deintv_en(deintv_en),
    .deintv_con(deintv_con), .signal_flag_in(signal_flag_in), .deintv_dout(deintv_dout),
    .deintv_vld(deintv_vld), .deintv_last(deintv_last), .deintv_type(deintv_type),
    .deintv_ovf(deintv_ovf)
  );

  always #5 cb_clk = ~cb_clk;

  typedef struct packed { logic d; logic last; logic [1:0] typ; } exp_t;
  exp_t exp_q[$];
  bit   out_log[$];
  int   runs[$];
  int   checks = 0, failures = 0, cyc = 0, run = 0, sym_idx = 0;
  int   first_vld_cyc = 0, last_in_cyc = 0;
  bit   sym_bits[288];
  bit   payload[288];
  exp_t e;

  always @(posedge cb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int n_of(input int con);
    case (con)
      0: return 48;
      1: return 96;
      2: return 192;
      default: return 288;
    endcase
  endfunction

  // Reference rules: the pair swap exchanges bit 1 in the upper half of each 24-bit group,
  // and the read position of output k is (N/16)*(k mod 16) + k/16.
  function automatic int wr_pos(input int j, input bit sig);
    return (!sig && (j % 24) >= 12) ? (j ^ 2) : j;
  endfunction

  function automatic int rd_pos(input int k, input int n);
    return (n / 16) * (k % 16) + k / 16;
  endfunction

  task automatic push_model(input int con, input bit sig);
    bit ram[288];
    int n;
    exp_t x;
    n = n_of(con);
    for (int j = 0; j < n; j++) ram[wr_pos(j, sig)] = sym_bits[j];
    for (int k = 0; k < n; k++) begin
      x.d = ram[rd_pos(k, n)];
      x.last = (k == n - 1);
      x.typ = 2'(con);
      exp_q.push_back(x);
    end
  endtask

  // Compare process: every valid output bit is checked against the next model entry.
  always @(negedge cb_clk) begin
    if (deintv_vld) begin
      run++;
      if (exp_q.size() == 0) begin
        check("unexpected_vld", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("stream_dout_last_type", int'({deintv_dout, deintv_last, deintv_type}), int'(e));
        if (sym_idx == 0) first_vld_cyc = cyc;
        sym_idx = e.last ? 0 : sym_idx + 1;
      end
      out_log.push_back(deintv_dout);
    end else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic send_sym(input int con, input bit sig, input int nbits, input int gap_pct,
                          input bit drop);
    int n;
    n = n_of(con);
    if (!drop && nbits == n) push_model(con, sig);
    for (int j = 0; j < nbits; j++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        @(posedge cb_clk); #1;
        deintv_en = 1'b0;
        deintv_din = 1'($urandom);
      end
      @(posedge cb_clk); #1;
      deintv_en = 1'b1;
      deintv_din = sym_bits[j];
      if (j == 0) begin
        deintv_con = 2'(con);
        signal_flag_in = sig;
      end else begin
        // Mid-symbol values must be ignored by the latched symbol parameters.
        deintv_con = 2'($urandom);
        signal_flag_in = 1'($urandom);
      end
      if (j == n - 1 && !drop) last_in_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int ncyc);
    repeat (ncyc) begin
      @(posedge cb_clk); #1;
      deintv_en = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge cb_clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout_remaining", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge cb_clk);
  endtask

  function automatic int last_run();
    return (runs.size() == 0) ? 0 : runs[runs.size() - 1];
  endfunction

  function automatic int first_one();
    for (int i = 0; i < out_log.size(); i++) if (out_log[i]) return i;
    return -1;
  endfunction

  function automatic int ones();
    int c;
    c = 0;
    foreach (out_log[i]) c += int'(out_log[i]);
    return c;
  endfunction

  task automatic fill_random();
    for (int j = 0; j < 288; j++) sym_bits[j] = 1'($urandom);
  endtask

  task automatic fill_zero();
    for (int j = 0; j < 288; j++) sym_bits[j] = 1'b0;
  endtask

  task automatic clear_logs();
    out_log.delete();
    runs.delete();
  endtask

  initial begin
    int mism;
    int con;
    // Reset state
    repeat (4) @(posedge cb_clk);
    @(negedge cb_clk);
    check("rst_vld", int'(deintv_vld), 0);
    check("rst_last", int'(deintv_last), 0);
    check("rst_dout", int'(deintv_dout), 0);
    check("rst_type", int'(deintv_type), 0);
    check("rst_ovf", int'(deintv_ovf), 0);
    @(posedge cb_clk); #1;
    rst_n = 1'b1;
    idle(2);

    // N=48 SIGNAL symbol with a single 1 at j=3 -> single 1 at k=1
    clear_logs(); fill_zero(); sym_bits[3] = 1'b1;
    send_sym(0, 1'b1, 48, 0, 1'b0);
    idle(1); wait_drain(2000);
    check("t48_len", out_log.size(), 48);
    check("t48_one_at", first_one(), 1);
    check("t48_ones", ones(), 1);
    check("t48_latency", first_vld_cyc - last_in_cyc, 3);
    check("t48_run", last_run(), 48);
    check("t48_type", int'(deintv_type), 0);

    // N=192 data symbol with a single 1 at j=12 -> swapped to 14 -> k=33
    clear_logs(); fill_zero(); sym_bits[12] = 1'b1;
    send_sym(2, 1'b0, 192, 20, 1'b0);
    idle(1); wait_drain(3000);
    check("t192_len", out_log.size(), 192);
    check("t192_one_at", first_one(), 33);
    check("t192_ones", ones(), 1);
    check("t192_latency", first_vld_cyc - last_in_cyc, 3);
    check("t192_type", int'(deintv_type), 2);

    // Round trip: payload through a transmit-side interleaver, then the DUT, returns the payload
    clear_logs();
    for (int k = 0; k < 288; k++) payload[k] = 1'($urandom);
    for (int k = 0; k < 288; k++) sym_bits[wr_pos(rd_pos(k, 288), 1'b0)] = payload[k];
    send_sym(3, 1'b0, 288, 25, 1'b0);
    idle(1); wait_drain(3000);
    mism = 0;
    for (int k = 0; k < 288; k++) if (k >= out_log.size() || out_log[k] != payload[k]) mism++;
    check("trip_mismatches", mism, 0);
    check("trip_latency", first_vld_cyc - last_in_cyc, 3);

    // Three back-to-back 96-bit symbols: one contiguous 288-bit burst, no overflow
    clear_logs();
    for (int s = 0; s < 3; s++) begin
      fill_random();
      send_sym(1, 1'($urandom), 96, 0, 1'b0);
    end
    idle(1); wait_drain(3000);
    check("b2b_len", out_log.size(), 288);
    check("b2b_run", last_run(), 288);
    check("b2b_ovf", int'(deintv_ovf), 0);

    // 288 then 48 then 48: the second 48 overflows and is dropped
    clear_logs();
    fill_random(); send_sym(3, 1'b0, 288, 0, 1'b0);
    fill_random(); send_sym(0, 1'b0, 48, 0, 1'b0);
    fill_random(); send_sym(0, 1'b1, 48, 0, 1'b1);
    idle(1); wait_drain(3000);
    check("ovf_flag", int'(deintv_ovf), 1);
    check("ovf_len", out_log.size(), 336);
    check("ovf_run", last_run(), 336);

    // Reset at j=100 of a 192 symbol, then a fresh 48
    fill_random(); send_sym(2, 1'b0, 100, 10, 1'b0);
    @(posedge cb_clk); #1;
    deintv_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge cb_clk);
    @(negedge cb_clk);
    check("rst2_ovf", int'(deintv_ovf), 0);
    check("rst2_vld", int'(deintv_vld), 0);
    @(posedge cb_clk); #1;
    rst_n = 1'b1;
    clear_logs();
    fill_random(); send_sym(0, 1'b0, 48, 0, 1'b0);
    idle(1); wait_drain(2000);
    idle(30);
    check("rst2_len", out_log.size(), 48);
    check("rst2_latency", first_vld_cyc - last_in_cyc, 3);

    // Random symbols with random enable gaps, engine idle between symbols
    for (int s = 0; s < 20; s++) begin
      con = int'($urandom_range(0, 3));
      fill_random();
      send_sym(con, 1'($urandom), n_of(con), int'($urandom_range(0, 40)), 1'b0);
      idle(int'($urandom_range(1, 4)));
      wait_drain(3000);
      check("rand_latency", first_vld_cyc - last_in_cyc, 3);
    end
    check("final_ovf", int'(deintv_ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
